// File: rtl/spart_rx_pkg.sv
// SPART receive-side shared definitions.
// Holds the receiver FSM state encoding, the default frame geometry
// (data bits per frame, oversample ticks per bit) and the tick index
// at which the start bit is re-checked at mid-bit.
package spart_rx_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // The start bit is re-checked on the 8th tick after the falling edge,
  // i.e. when the tick counter (cleared on detection) reads 7.
  localparam int MID_TICK = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spart_rx_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input.
// Both flops reset to RST_VAL so an idle-high serial line looks idle
// immediately after reset.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset
//   i_d  - asynchronous input
//   o_q  - synchronized output (two clk of latency)
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spart_rx.sv
// spart_rx: 8N1 serial receiver driven by an external oversample tick.
// The line is synchronized, a falling edge starts a frame, the start bit
// is re-checked at mid-bit to reject glitches, data bits are shifted in
// LSB-first once per bit period, and the stop bit sample loads the
// receive buffer and updates the status flags.
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-high reset
//   rx_enable   - one-clk oversample tick (OVERSAMPLE ticks per bit)
//   rxd         - asynchronous serial input, idle high
//   rd_ack      - one-clk pulse, host has read the receive buffer
//   rx_data     - last received byte
//   rda         - receive data available
//   framing_err - last frame's stop bit sampled 0 (held until next frame)
//   overrun     - a byte completed while rda was still set
module spart_rx
  import spart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(MID_TICK);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_rxs;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rda;
  logic                 r_framing_err;
  logic                 r_overrun;

  logic                 w_tick_clr;
  logic                 w_tick_inc;
  logic                 w_bit_clr;
  logic                 w_shift_en;
  logic                 w_stop_smp;

  sync2 #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // All FSM activity is gated by the oversample tick; between ticks
  // every counter and the state simply hold.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_clr  = 1'b0;
    w_tick_inc  = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_smp  = 1'b0;
    if (rx_enable) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = ST_START;
            w_tick_clr  = 1'b1;
          end
        end
        ST_START: begin
          if (r_tick == TICK_MID) begin
            // A line that is high again at mid-bit was only a glitch.
            w_tick_clr  = 1'b1;
            w_bit_clr   = 1'b1;
            w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
        ST_DATA: begin
          if (r_tick == TICK_LAST) begin
            w_tick_clr = 1'b1;
            w_shift_en = 1'b1;
            if (r_bit == BIT_LAST) w_state_nxt = ST_STOP;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
        ST_STOP: begin
          if (r_tick == TICK_LAST) begin
            w_tick_clr  = 1'b1;
            w_stop_smp  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_tick_clr)      r_tick <= '0;
      else if (w_tick_inc) r_tick <= r_tick + TW'(1);

      if (w_bit_clr)       r_bit <= '0;
      else if (w_shift_en) r_bit <= r_bit + BW'(1);

      // LSB arrives first, so shift in from the top.
      if (w_shift_en) r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
    end
  end

  // A stop sample always delivers its byte, even when the host acks in
  // the same cycle: the new byte wins and overrun is left untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data     <= '0;
      r_rda         <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (w_stop_smp) begin
      r_rx_data     <= r_shift;
      r_rda         <= 1'b1;
      r_framing_err <= ~w_rxs;
      if (r_rda && !rd_ack) r_overrun <= 1'b1;
    end else if (rd_ack && r_rda) begin
      r_rda     <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign rx_data     = r_rx_data;
  assign rda         = r_rda;
  assign framing_err = r_framing_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_spart_rx.sv
// Testbench for spart_rx: directed scenarios plus randomized frames,
// checked against a host-level model of the receive buffer and flags.
module tb_spart_rx;

  localparam int DIV     = 4;   // clk cycles per oversample tick
  localparam int OS      = 16;
  localparam int STOP_TK = 153; // tick index (from first start-bit tick) of stop sample

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_enable;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: what the host should see.
  logic [7:0] m_data;
  logic       m_rda, m_fe, m_ovr;

  spart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_enable   (rx_enable),
    .rxd         (rxd),
    .rd_ack      (rd_ack),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, 32'(rx_data), 32'(m_data));
    check({tag, ".rda"},  32'(rda),     32'(m_rda));
    check({tag, ".fe"},   32'(framing_err), 32'(m_fe));
    check({tag, ".ovr"},  32'(overrun), 32'(m_ovr));
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
  endtask

  // One oversample period; the tick lands on the last clk. Called and
  // returns at a falling clk edge.
  task automatic do_tick(input bit ack);
    for (int i = 0; i < DIV; i++) begin
      rx_enable = (i == DIV - 1);
      rd_ack    = ack && (i == DIV - 1);
      @(negedge clk);
    end
    rx_enable = 1'b0;
    rd_ack    = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    rxd = 1'b1;
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  // Drive a complete 8N1 frame, one bit per OS ticks. Optionally pulse
  // rd_ack on the stop-sample tick, or pulse rst at a given tick.
  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input bit ack_stop, input int rst_tick);
    int idx;
    bit aborted = 1'b0;
    for (int t = 1; t <= 10 * OS; t++) begin
      idx = (t - 1) / OS;
      if (idx == 0)      rxd = 1'b0;
      else if (idx == 9) rxd = stop;
      else               rxd = d[idx-1];
      if (t == rst_tick) begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        model_reset();
      end
      do_tick(ack_stop && (t == STOP_TK) && !aborted);
      if (!aborted && t == STOP_TK - 1)
        check("pre_stop.rda", 32'(rda), 32'(m_rda));
      if (!aborted && t == STOP_TK) begin
        // Host-level effect of a completed frame.
        if (m_rda && !ack_stop) m_ovr = 1'b1;
        m_rda  = 1'b1;
        m_data = d;
        m_fe   = !stop;
        check("stop_latency.rda", 32'(rda), 32'(m_rda));
      end
    end
    idle_ticks(20);
  endtask

  task automatic host_ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    if (m_rda) begin
      m_rda = 1'b0;
      m_ovr = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    bit s, a;
    rst = 1'b1; rx_enable = 1'b0; rxd = 1'b1; rd_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    idle_ticks(5);
    check_all("post_reset_idle");

    // Good frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    check_all("frame_A5");
    host_ack();
    check_all("ack_A5");

    // Short 0 glitch must not produce a byte; the next frame is intact.
    rxd = 1'b0;
    for (int i = 0; i < 4; i++) do_tick(1'b0);
    idle_ticks(24);
    check_all("glitch");
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    check_all("frame_3C");
    host_ack();

    // Framing error, then cleared by the next good frame.
    send_frame(8'h55, 1'b0, 1'b0, 0);
    check_all("frame_55_fe");
    host_ack();
    check_all("ack_keeps_fe");
    send_frame(8'h0F, 1'b1, 1'b0, 0);
    check_all("frame_0F");
    host_ack();

    // Overrun.
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    check_all("overrun_22");
    host_ack();
    check_all("ack_overrun");

    // rd_ack with nothing pending.
    host_ack();
    check_all("ack_empty");

    // rd_ack coinciding with the stop sample while a byte is pending.
    send_frame(8'h66, 1'b1, 1'b0, 0);
    send_frame(8'h77, 1'b1, 1'b1, 0);
    check_all("ack_on_stop_77");
    host_ack();

    // Reset in the middle of data bit 3, then a clean frame.
    send_frame(8'h44, 1'b0, 1'b0, 0);   // leave flags set before the reset
    send_frame(8'hFF, 1'b1, 1'b0, OS * 4 + 8);
    check_all("after_abort");
    send_frame(8'h81, 1'b1, 1'b0, 0);
    check_all("frame_81");
    host_ack();

    // Randomized traffic.
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0);
      send_frame(d, s, a, 0);
      check_all("rand_frame");
      if ($urandom_range(0, 1) == 1) begin
        host_ack();
        check_all("rand_ack");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
